// File: rtl/pong_sync_gen_if.sv
// Signal bundle between the Pong H/V timing chain and the decode logic it feeds.
// The master side produces the counts and strobes; the slave side supplies ce_pix.
interface pong_sync_gen_if;
    logic       ce_pix;
    logic [8:0] h;
    logic [8:0] v;
    logic       hreset;
    logic       vreset;
    logic       hblank;
    logic       vblank;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_start;

    modport master (
        input  ce_pix,
        output h, v, hreset, vreset, hblank, vblank, hsync_n, vsync_n, frame_start
    );

    modport slave (
        output ce_pix,
        input  h, v, hreset, vreset, hblank, vblank, hsync_n, vsync_n, frame_start
    );
endinterface

// File: rtl/pong_sync_gen.sv
// Pong horizontal/vertical timing chain: H/V counters with registered blank, sync
// and reset strobes, advancing only on the pixel clock enable.
module pong_sync_gen #(
    parameter int H_TOTAL     = 455,
    parameter int V_TOTAL     = 262,
    parameter int HBLANK_END  = 80,
    parameter int HSYNC_START = 32,
    parameter int HSYNC_END   = 64,
    parameter int VBLANK_END  = 16,
    parameter int VSYNC_START = 4,
    parameter int VSYNC_END   = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    pong_sync_gen_if.master bus
);

    localparam bit PARAMS_OK =
        (H_TOTAL >= 2) && (H_TOTAL <= 512) && (V_TOTAL >= 2) && (V_TOTAL <= 512) &&
        (HSYNC_START < HSYNC_END) && (HSYNC_END <= HBLANK_END) && (HBLANK_END <= H_TOTAL) &&
        (VSYNC_START < VSYNC_END) && (VSYNC_END <= VBLANK_END) && (VBLANK_END <= V_TOTAL);

    if (!PARAMS_OK) begin : g_param_check
        $error("pong_sync_gen: illegal timing parameters");
    end

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    // Window bounds may equal 512, so the decodes compare in 10 bits.
    localparam logic [9:0] HBLANK_END_X  = 10'(HBLANK_END);
    localparam logic [9:0] HSYNC_START_X = 10'(HSYNC_START);
    localparam logic [9:0] HSYNC_END_X   = 10'(HSYNC_END);
    localparam logic [9:0] VBLANK_END_X  = 10'(VBLANK_END);
    localparam logic [9:0] VSYNC_START_X = 10'(VSYNC_START);
    localparam logic [9:0] VSYNC_END_X   = 10'(VSYNC_END);

    logic [8:0] r_h;
    logic [8:0] r_v;
    logic       r_hreset;
    logic       r_vreset;
    logic       r_hblank;
    logic       r_vblank;
    logic       r_hsync_n;
    logic       r_vsync_n;
    logic       r_frame_start;

    logic       w_h_last;
    logic       w_v_last;
    logic [8:0] w_h_next;
    logic [8:0] w_v_next;
    logic [9:0] w_h_next_x;
    logic [9:0] w_v_next_x;

    assign w_h_last   = (r_h == H_LAST);
    assign w_v_last   = (r_v == V_LAST);
    assign w_h_next   = w_h_last ? 9'd0 : r_h + 9'd1;
    assign w_v_next   = !w_h_last ? r_v : (w_v_last ? 9'd0 : r_v + 9'd1);
    assign w_h_next_x = {1'b0, w_h_next};
    assign w_v_next_x = {1'b0, w_v_next};

    // Strobes decode the next count so they land on the same edge as h/v.
    // NOTE: reset is sampled inside the clocked block (synchronous), and all
    // state uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hreset      <= 1'b0;
            r_vreset      <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (bus.ce_pix) begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hreset      <= (w_h_next == H_LAST);
            r_vreset      <= (w_h_next == H_LAST) && (w_v_next == V_LAST);
            r_hblank      <= (w_h_next_x < HBLANK_END_X);
            r_vblank      <= (w_v_next_x < VBLANK_END_X);
            r_hsync_n     <= !((w_h_next_x >= HSYNC_START_X) && (w_h_next_x < HSYNC_END_X));
            r_vsync_n     <= !((w_v_next_x >= VSYNC_START_X) && (w_v_next_x < VSYNC_END_X));
            r_frame_start <= w_h_last && w_v_last;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign bus.h           = r_h;
    assign bus.v           = r_v;
    assign bus.hreset      = r_hreset;
    assign bus.vreset      = r_vreset;
    assign bus.hblank      = r_hblank;
    assign bus.vblank      = r_vblank;
    assign bus.hsync_n     = r_hsync_n;
    assign bus.vsync_n     = r_vsync_n;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_pong_sync_gen.sv
// Directed bench for pong_sync_gen: default timing on one instance, a 5x3 frame
// on a second instance for wrap, frame period and clock-enable behaviour.
module tb_pong_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    pong_sync_gen_if bus_a ();
    pong_sync_gen_if bus_b ();

    pong_sync_gen u_dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .bus     (bus_a.master)
    );

    pong_sync_gen #(
        .H_TOTAL    (5),
        .V_TOTAL    (3),
        .HBLANK_END (3),
        .HSYNC_START(1),
        .HSYNC_END  (2),
        .VBLANK_END (2),
        .VSYNC_START(1),
        .VSYNC_END  (2)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .bus     (bus_b.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state for each instance, advanced by the bench on every clk.
    int ah = 0, av = 0, bh = 0, bv = 0;
    bit afs = 1'b0, bfs = 1'b0;
    int bad_a = 0, bad_b = 0;
    int vs_lo_min = 999, vs_lo_max = -1, vb_hi_max = -1, fs_cnt_a = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int ht, input int vt, input logic rst_n, input logic ce,
                              inout int eh, inout int ev, inout bit efs);
        if (!rst_n) begin
            eh  = 0;
            ev  = 0;
            efs = 1'b0;
        end else if (ce) begin
            efs = (eh == ht - 1) && (ev == vt - 1);
            if (eh == ht - 1) begin
                eh = 0;
                ev = (ev == vt - 1) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
        end else begin
            efs = 1'b0;
        end
    endtask

    function automatic int out_errs(input int ht, input int vt, input int hbe, input int hss,
                                    input int hse, input int vbe, input int vss, input int vse,
                                    input int eh, input int ev, input bit efs,
                                    input logic [8:0] h, input logic [8:0] v,
                                    input logic hr, input logic vr, input logic hb,
                                    input logic vb, input logic hs, input logic vs,
                                    input logic fs);
        int e = 0;
        if (h !== eh[8:0]) e++;
        if (v !== ev[8:0]) e++;
        if (hr !== (eh == ht - 1)) e++;
        if (vr !== ((eh == ht - 1) && (ev == vt - 1))) e++;
        if (hb !== (eh < hbe)) e++;
        if (vb !== (ev < vbe)) e++;
        if (hs !== !((eh >= hss) && (eh < hse))) e++;
        if (vs !== !((ev >= vss) && (ev < vse))) e++;
        if (fs !== efs) e++;
        return e;
    endfunction

    task automatic step_a(input logic ce);
        bus_a.ce_pix = ce;
        @(posedge clk);
        #1;
        model_step(455, 262, rst_a_n, ce, ah, av, afs);
        bad_a += out_errs(455, 262, 80, 32, 64, 16, 4, 8, ah, av, afs,
                          bus_a.h, bus_a.v, bus_a.hreset, bus_a.vreset, bus_a.hblank,
                          bus_a.vblank, bus_a.hsync_n, bus_a.vsync_n, bus_a.frame_start);
        if (rst_a_n) begin
            if (!bus_a.vsync_n) begin
                if (int'(bus_a.v) < vs_lo_min) vs_lo_min = int'(bus_a.v);
                if (int'(bus_a.v) > vs_lo_max) vs_lo_max = int'(bus_a.v);
            end
            if (bus_a.vblank && int'(bus_a.v) > vb_hi_max) vb_hi_max = int'(bus_a.v);
            if (bus_a.frame_start) fs_cnt_a++;
        end
    endtask

    task automatic step_b(input logic ce);
        bus_b.ce_pix = ce;
        @(posedge clk);
        #1;
        model_step(5, 3, rst_b_n, ce, bh, bv, bfs);
        bad_b += out_errs(5, 3, 3, 1, 2, 2, 1, 2, bh, bv, bfs,
                          bus_b.h, bus_b.v, bus_b.hreset, bus_b.vreset, bus_b.hblank,
                          bus_b.vblank, bus_b.hsync_n, bus_b.vsync_n, bus_b.frame_start);
    endtask

    initial begin
        int hs_fall = -1, hs_rise = -1, hb_fall = -1, hr_cnt = 0, hr_h = -1, hr_hold = 0;
        int guard = 0;
        int fs_cnt = 0, fs_first = -1, fs_last = -1;
        logic prev_hs, prev_hb;

        rst_a_n      = 1'b0;
        rst_b_n      = 1'b0;
        bus_a.ce_pix = 1'b1;
        bus_b.ce_pix = 1'b0;

        // Reset held 3 clks with the enable high.
        repeat (3) step_a(1'b1);
        check("rst_h",           32'(bus_a.h), 0);
        check("rst_v",           32'(bus_a.v), 0);
        check("rst_hblank",      32'(bus_a.hblank), 1);
        check("rst_vblank",      32'(bus_a.vblank), 1);
        check("rst_hsync_n",     32'(bus_a.hsync_n), 1);
        check("rst_vsync_n",     32'(bus_a.vsync_n), 1);
        check("rst_frame_start", 32'(bus_a.frame_start), 0);
        check("rst_hreset",      32'(bus_a.hreset), 0);
        check("rst_vreset",      32'(bus_a.vreset), 0);

        // First line: horizontal decode edges.
        rst_a_n = 1'b1;
        step_a(1'b1);
        check("first_ce_h", 32'(bus_a.h), 1);
        check("first_ce_v", 32'(bus_a.v), 0);
        prev_hs = bus_a.hsync_n;
        prev_hb = bus_a.hblank;
        for (int n = 2; n <= 455; n++) begin
            step_a(1'b1);
            if (prev_hs && !bus_a.hsync_n) hs_fall = int'(bus_a.h);
            if (!prev_hs && bus_a.hsync_n) hs_rise = int'(bus_a.h);
            if (prev_hb && !bus_a.hblank) hb_fall = int'(bus_a.h);
            if (bus_a.hreset) begin
                hr_cnt++;
                hr_h = int'(bus_a.h);
            end
            prev_hs = bus_a.hsync_n;
            prev_hb = bus_a.hblank;
        end
        check("hsync_fall_h",  32'(hs_fall), 32);
        check("hsync_rise_h",  32'(hs_rise), 64);
        check("hblank_fall_h", 32'(hb_fall), 80);
        check("hreset_count",  32'(hr_cnt), 1);
        check("hreset_at_h",   32'(hr_h), 454);
        check("line_wrap_h",   32'(bus_a.h), 0);
        check("line_wrap_v",   32'(bus_a.v), 1);

        // hreset stays high across disabled clks at h=454.
        repeat (454) step_a(1'b1);
        check("pre_gap_h", 32'(bus_a.h), 454);
        for (int k = 0; k < 3; k++) begin
            step_a(1'b0);
            if (bus_a.hreset) hr_hold++;
        end
        check("hreset_hold", 32'(hr_hold), 3);
        check("gap_hold_h",  32'(bus_a.h), 454);
        check("gap_hold_v",  32'(bus_a.v), 1);

        // Run down to (200,20): (454,1)->(0,2) is 1 edge, 18 lines, then 200.
        while (!(bus_a.h == 9'd200 && bus_a.v == 9'd20) && guard < 20000) begin
            step_a(1'b1);
            guard++;
        end
        check("seek_edges",     32'(guard), 8391);
        check("vsync_low_min",  32'(vs_lo_min), 4);
        check("vsync_low_max",  32'(vs_lo_max), 7);
        check("vblank_high_max", 32'(vb_hi_max), 15);

        // One-clk reset mid-frame with the enable high.
        rst_a_n = 1'b0;
        step_a(1'b1);
        check("midrst_h",      32'(bus_a.h), 0);
        check("midrst_v",      32'(bus_a.v), 0);
        check("midrst_fs",     32'(bus_a.frame_start), 0);
        check("midrst_hblank", 32'(bus_a.hblank), 1);
        rst_a_n = 1'b1;
        step_a(1'b1);
        check("resume_h",      32'(bus_a.h), 1);
        check("resume_v",      32'(bus_a.v), 0);
        check("a_frame_start_count", 32'(fs_cnt_a), 0);
        check("a_per_clk_errors",    32'(bad_a), 0);
        bus_a.ce_pix = 1'b0;

        // Small frame: 5 pixels x 3 lines = 15 edges per frame.
        repeat (2) step_b(1'b1);
        check("b_rst_h", 32'(bus_b.h), 0);
        check("b_rst_v", 32'(bus_b.v), 0);
        rst_b_n = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            step_b(1'b1);
            if (bus_b.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                fs_last = n;
            end
            if (n == 4) begin
                check("b_e4_h",      32'(bus_b.h), 4);
                check("b_e4_hreset", 32'(bus_b.hreset), 1);
            end
            if (n == 5) begin
                check("b_e5_h", 32'(bus_b.h), 0);
                check("b_e5_v", 32'(bus_b.v), 1);
            end
            if (n == 14) begin
                check("b_e14_v",      32'(bus_b.v), 2);
                check("b_e14_vreset", 32'(bus_b.vreset), 1);
            end
            if (n == 15) begin
                check("b_e15_h",  32'(bus_b.h), 0);
                check("b_e15_v",  32'(bus_b.v), 0);
                check("b_e15_fs", 32'(bus_b.frame_start), 1);
            end
            if (n == 16) check("b_e16_fs", 32'(bus_b.frame_start), 0);
        end
        check("b_fs_count", 32'(fs_cnt), 3);
        check("b_fs_first", 32'(fs_first), 15);
        check("b_fs_last",  32'(fs_last), 45);

        // Enable at 1-in-4: 15th enabled clk is k=56, frame is 60 clks.
        fs_cnt   = 0;
        fs_first = -1;
        fs_last  = -1;
        for (int k = 0; k < 120; k++) begin
            step_b((k % 4) == 0);
            if (bus_b.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                fs_last = k;
            end
            if (k == 28) begin
                check("ce4_k28_h", 32'(bus_b.h), 3);
                check("ce4_k28_v", 32'(bus_b.v), 1);
            end
            if (k == 29) check("ce4_k29_hold_h", 32'(bus_b.h), 3);
        end
        check("ce4_fs_first",  32'(fs_first), 56);
        check("ce4_fs_period", 32'(fs_last - fs_first), 60);
        check("ce4_fs_clks",   32'(fs_cnt), 2);
        check("b_per_clk_errors", 32'(bad_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
